cdc_wr_packer: RTL and testbench
================================

# cdc_wr_packer

Write-domain packing stage that sits directly upstream of the team's asynchronous CDC FIFO. It accepts narrow beats over a valid/ready stream and packs RATIO beats into one wide FIFO word tagged with a beat count and last flag. It drives the FIFO write port, back-pressures on FIFO full, and flushes partial words on frame end or idle timeout. It also reports FIFO almost-full status and a write counter to write-domain logic.

## Interface
- IN_WIDTH, 8: width of one input beat.
- RATIO, 4: beats per FIFO word; power of 2, >= 2.
- SLOTS, 2: depth of the downstream FIFO; power of 2, >= 2.
- AF_MARGIN, 1: almost_full_o asserts when FIFO occupancy >= SLOTS - AF_MARGIN; 0 <= AF_MARGIN < SLOTS.
- TIMEOUT, 16: idle cycles before a partial word is flushed; 0 disables the timeout.
- OUT_WIDTH is derived, not a parameter: RATIO*IN_WIDTH + $clog2(RATIO) + 1.

Ports:
- clk_wr  in  1  write-domain clock.
- arst_wr  in  1  reset, asynchronous, active-high.
- in_valid_i  in  1  input beat valid.
- in_data_i  in  IN_WIDTH  input beat data.
- in_last_i  in  1  beat ends a frame.
- in_ready_o  out  1  beat accepted when in_valid_i && in_ready_o.
- fifo_wr_en_o  out  1  FIFO write strobe.
- fifo_wr_data_o  out  OUT_WIDTH  FIFO write word, packed as {last, cnt, data}.
- fifo_full_i  in  1  FIFO full flag.
- fifo_ocup_i  in  $clog2(SLOTS)+1  FIFO occupancy, write domain.
- almost_full_o  out  1  registered almost-full indication.
- words_o  out  16  count of FIFO writes; wraps modulo 2^16.

## Operation
**Accumulator**
- acc_data: RATIO lanes. idx: $clog2(RATIO) bits, next free lane. acc_ts: timeout counter.
- An accepted beat writes lane idx. Lane 0 holds the first beat, in bits [IN_WIDTH-1:0].
- A beat completes the word when idx == RATIO-1 or in_last_i == 1.
- On completion, the word moves to the output register and idx returns to 0.
- Otherwise idx increments by 1.

**Output register**
- Fields: out_valid, out_data (OUT_WIDTH).
- Data field: lanes as accumulated. Unused upper lanes are zero.
- cnt field: number of valid beats minus 1.
- last field: in_last_i of the completing beat, or 0 when the word was flushed by timeout.
- fifo_wr_en_o = out_valid && !fifo_full_i (combinational).
- fifo_wr_data_o = out_data.
- out_valid clears after a write unless a new word loads in the same cycle.

**Handshake**
- in_ready_o = !arst_wr && (!out_valid || !fifo_full_i).
- in_ready_o does not depend on in_valid_i or in_last_i.

**Timeout**
- While idx != 0 and no beat is accepted, acc_ts increments.
- When acc_ts == TIMEOUT-1 and the output register is free or draining this cycle, the partial word loads with last = 0, then idx = 0 and acc_ts = 0.
- If the output register is blocked, acc_ts saturates and the flush occurs on the first cycle it is free or draining.
- Any accepted beat clears acc_ts.
- If a beat is accepted in the same cycle as timeout expiry, the beat wins: it is appended normally and the timer restarts.

**Status**
- almost_full_o <= (fifo_ocup_i >= SLOTS - AF_MARGIN), registered.
- words_o increments on every fifo_wr_en_o cycle.

**Reset**
- Asynchronous reset clears: idx, acc_ts, out_valid, almost_full_o, words_o.
- acc_data and out_data are don't-care. fifo_wr_en_o = 0.
- Reset mid-word drops the partial word and any pending output word without writing them.

## Timing
- Reset values: in_ready_o 0 during reset and 1 on the first cycle after; fifo_wr_en_o 0; almost_full_o 0; words_o 0; fifo_wr_data_o undefined.
- A completing beat accepted in cycle N gives fifo_wr_en_o high in N+1 if fifo_full_i is low.
- A blocked word holds fifo_wr_data_o stable until it is written.
- Sustained throughput is one FIFO word per RATIO beats, with no bubbles.
- Back-to-back word loads are allowed while the output register drains.
- A timeout flush writes at most TIMEOUT+1 cycles after the last accepted beat, given a non-full FIFO.
- almost_full_o lags fifo_ocup_i by 1 cycle.
- fifo_ocup_i and fifo_full_i come from the FIFO's write-side synchronized pointers, so they are pessimistic; no correction is applied.

## Test plan
- **Full words:** RATIO=4, IN_WIDTH=8, stream beats 0x01..0x08 with last on 0x08 and FIFO never full -> two writes: {0,3,0x04030201} then {1,3,0x08070605}; words_o = 2.
- **Short frame:** beats 0xAA, 0xBB with last on 0xBB -> one write {1,1,0x0000BBAA} one cycle after the 0xBB handshake.
- **Timeout flush:** TIMEOUT=16, single beat 0x5A with no last, then idle -> write {0,0,0x0000005A} exactly 17 cycles after acceptance; a beat arriving on the expiry cycle is appended instead.
- **Backpressure:** hold fifo_full_i=1 with one word pending -> in_ready_o=0, fifo_wr_en_o=0, data stable; release -> word written that cycle and in_ready_o=1 in the same cycle.
- **Almost full:** SLOTS=4, AF_MARGIN=1, drive fifo_ocup_i 2 then 3 -> almost_full_o rises one cycle after 3 appears.
- **Reset mid-word:** pulse arst_wr after 2 beats with a word pending -> no FIFO write; words_o=0; the next 4 beats produce one word starting in lane 0.

Source files
------------

// File: rtl/cdc_wr_packer.sv
// Write-side packer in front of the async CDC FIFO: gathers RATIO
// narrow beats into one tagged FIFO word, with partial-word flushing.
module cdc_wr_packer #(
    parameter int IN_WIDTH  = 8,
    parameter int RATIO     = 4,
    parameter int SLOTS     = 2,
    parameter int AF_MARGIN = 1,
    parameter int TIMEOUT   = 16,
    localparam int IDX_W     = $clog2(RATIO),
    localparam int OCW       = $clog2(SLOTS) + 1,
    localparam int OUT_WIDTH = RATIO * IN_WIDTH + IDX_W + 1
) (
    input  logic                 clk_wr,
    input  logic                 arst_wr,
    input  logic                 in_valid_i,
    input  logic [IN_WIDTH-1:0]  in_data_i,
    input  logic                 in_last_i,
    output logic                 in_ready_o,
    output logic                 fifo_wr_en_o,
    output logic [OUT_WIDTH-1:0] fifo_wr_data_o,
    input  logic                 fifo_full_i,
    input  logic [OCW-1:0]       fifo_ocup_i,
    output logic                 almost_full_o,
    output logic [15:0]          words_o
);

    localparam int TS_W = (TIMEOUT > 1) ? $clog2(TIMEOUT) : 1;
    localparam logic [TS_W-1:0] TS_MAX =
        TS_W'((TIMEOUT > 0) ? TIMEOUT - 1 : 0);
    localparam logic [IDX_W-1:0] IDX_MAX = IDX_W'(RATIO - 1);
    localparam logic [OCW-1:0] AF_LEVEL = OCW'(SLOTS - AF_MARGIN);

    logic [RATIO-1:0][IN_WIDTH-1:0] r_acc;
    logic [IDX_W-1:0]               r_idx;
    logic [TS_W-1:0]                r_ts;
    logic                           r_out_valid;
    logic [OUT_WIDTH-1:0]           r_out_data;
    logic                           r_af;
    logic [15:0]                    r_words;

    logic                           w_out_free;
    logic                           w_drain;
    logic                           w_accept;
    logic                           w_complete;
    logic                           w_flush;
    logic                           w_load;
    logic [RATIO-1:0][IN_WIDTH-1:0] w_lanes;
    logic [IDX_W-1:0]               w_cnt;
    logic                           w_last;
    logic [OUT_WIDTH-1:0]           w_word;

    assign w_out_free = !r_out_valid || !fifo_full_i;
    assign w_drain    = r_out_valid && !fifo_full_i;
    assign in_ready_o = !arst_wr && w_out_free;
    assign w_accept   = in_valid_i && in_ready_o;
    assign w_complete = w_accept && (r_idx == IDX_MAX || in_last_i);
    assign w_flush    = (TIMEOUT != 0) && !w_accept && (r_idx != '0)
                        && (r_ts == TS_MAX) && w_out_free;
    assign w_load     = w_complete || w_flush;

    assign fifo_wr_en_o   = w_drain;
    assign fifo_wr_data_o = r_out_data;
    assign almost_full_o  = r_af;
    assign words_o        = r_words;

    // Build the outgoing word: filled lanes, the completing beat, zeros above.
    always_comb begin
        w_lanes = '0;
        for (int j = 0; j < RATIO; j++) begin
            if (IDX_W'(j) < r_idx) begin
                w_lanes[j] = r_acc[j];
            end else if (IDX_W'(j) == r_idx && w_complete) begin
                w_lanes[j] = in_data_i;
            end
        end
        w_cnt  = w_complete ? r_idx : r_idx - IDX_W'(1);
        w_last = w_complete ? in_last_i : 1'b0;
        w_word = {w_last, w_cnt, w_lanes};
    end

    // Lane fill pointer and idle timer for the partial word.
    always_ff @(posedge clk_wr or posedge arst_wr) begin
        if (arst_wr) begin
            r_idx <= '0;
            r_ts  <= '0;
        end else begin
            if (w_load) begin
                r_idx <= '0;
            end else if (w_accept) begin
                r_idx <= r_idx + IDX_W'(1);
            end
            if (w_accept || w_flush) begin
                r_ts <= '0;
            end else if (r_idx != '0 && r_ts != TS_MAX) begin
                r_ts <= r_ts + TS_W'(1);
            end
        end
    end

    // Lane storage; contents are meaningless until written.
    always_ff @(posedge clk_wr) begin
        if (w_accept) begin
            r_acc[r_idx] <= in_data_i;
        end
    end

    // Output word valid: set on load, cleared once the FIFO takes it.
    always_ff @(posedge clk_wr or posedge arst_wr) begin
        if (arst_wr) begin
            r_out_valid <= 1'b0;
        end else if (w_load) begin
            r_out_valid <= 1'b1;
        end else if (w_drain) begin
            r_out_valid <= 1'b0;
        end
    end

    // Output word payload, held stable while the FIFO is full.
    always_ff @(posedge clk_wr) begin
        if (w_load) begin
            r_out_data <= w_word;
        end
    end

    // Registered almost-full flag and wrapping write counter.
    always_ff @(posedge clk_wr or posedge arst_wr) begin
        if (arst_wr) begin
            r_af    <= 1'b0;
            r_words <= '0;
        end else begin
            r_af <= (fifo_ocup_i >= AF_LEVEL);
            if (w_drain) begin
                r_words <= r_words + 16'd1;
            end
        end
    end

endmodule

// File: tb/tb_cdc_wr_packer.sv
// Directed bench for cdc_wr_packer: scoreboard of expected FIFO words,
// immediate assertions on every check.
module tb_cdc_wr_packer;

    localparam int W = 35;

    logic          clk_wr = 1'b0;
    logic          arst_wr;
    logic          in_valid_i;
    logic [7:0]    in_data_i;
    logic          in_last_i;
    logic          in_ready_o;
    logic          fifo_wr_en_o;
    logic [W-1:0]  fifo_wr_data_o;
    logic          fifo_full_i;
    logic [2:0]    fifo_ocup_i;
    logic          almost_full_o;
    logic [15:0]   words_o;

    int n_assert = 0;
    int n_fail   = 0;
    int cyc      = 0;
    int n_wr     = 0;
    int last_wr_cyc = -1;
    int acc_cyc  = -1;
    logic [W-1:0] sb[$];

    cdc_wr_packer #(
        .IN_WIDTH(8), .RATIO(4), .SLOTS(4),
        .AF_MARGIN(1), .TIMEOUT(16)
    ) dut (
        .clk_wr(clk_wr),
        .arst_wr(arst_wr),
        .in_valid_i(in_valid_i),
        .in_data_i(in_data_i),
        .in_last_i(in_last_i),
        .in_ready_o(in_ready_o),
        .fifo_wr_en_o(fifo_wr_en_o),
        .fifo_wr_data_o(fifo_wr_data_o),
        .fifo_full_i(fifo_full_i),
        .fifo_ocup_i(fifo_ocup_i),
        .almost_full_o(almost_full_o),
        .words_o(words_o)
    );

    always #5 clk_wr = ~clk_wr;

    always @(posedge clk_wr) cyc++;

    task automatic chk(input string tag, input logic [63:0] obs,
                       input logic [63:0] exp);
        n_assert++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    always @(negedge clk_wr) begin
        if (fifo_wr_en_o === 1'b1) begin
            n_wr++;
            last_wr_cyc = cyc;
            n_assert++;
            assert (sb.size() != 0) else begin
                n_fail++;
                $error("FAIL unexpected_write observed=%0h expected=none",
                       fifo_wr_data_o);
            end
            if (sb.size() != 0) begin
                chk("wr_data", 64'(fifo_wr_data_o), 64'(sb.pop_front()));
            end
        end
    end

    task automatic beat(input logic [7:0] d, input logic l);
        bit got;
        got = 0;
        in_valid_i = 1'b1;
        in_data_i  = d;
        in_last_i  = l;
        for (int i = 0; i < 50; i++) begin
            @(negedge clk_wr);
            if (in_ready_o === 1'b1) begin
                got = 1;
                break;
            end
        end
        chk("beat_accept", 64'(got), 64'd1);
        acc_cyc = cyc;
        @(posedge clk_wr);
        #1;
        in_valid_i = 1'b0;
        in_last_i  = 1'b0;
    endtask

    task automatic wait_wr(input int n);
        for (int i = 0; i < 100; i++) begin
            if (n_wr >= n) break;
            @(posedge clk_wr);
            #1;
        end
        chk("wr_count", 64'(n_wr >= n), 64'd1);
    endtask

    task automatic cycles(input int n);
        repeat (n) @(posedge clk_wr);
        #1;
    endtask

    initial begin
        int c4;
        int a1;
        int base;
        arst_wr     = 1'b1;
        in_valid_i  = 1'b0;
        in_data_i   = '0;
        in_last_i   = 1'b0;
        fifo_full_i = 1'b0;
        fifo_ocup_i = '0;
        #2;
        chk("rst_ready", 64'(in_ready_o), 64'd0);
        chk("rst_wr_en", 64'(fifo_wr_en_o), 64'd0);
        chk("rst_af", 64'(almost_full_o), 64'd0);
        chk("rst_words", 64'(words_o), 64'd0);
        cycles(2);
        arst_wr = 1'b0;
        @(negedge clk_wr);
        chk("post_rst_ready", 64'(in_ready_o), 64'd1);
        cycles(1);

        // full words, back to back
        sb.push_back({1'b0, 2'd3, 32'h04030201});
        sb.push_back({1'b1, 2'd3, 32'h08070605});
        for (int i = 1; i <= 8; i++) begin
            beat(8'(i), i == 8);
            if (i == 4) c4 = acc_cyc;
        end
        chk("no_bubble", 64'(acc_cyc - c4), 64'd4);
        wait_wr(2);
        chk("full_lat", 64'(last_wr_cyc), 64'(acc_cyc + 1));
        chk("words_2", 64'(words_o), 64'd2);

        // short frame
        sb.push_back({1'b1, 2'd1, 32'h0000BBAA});
        beat(8'hAA, 1'b0);
        beat(8'hBB, 1'b1);
        wait_wr(3);
        chk("short_lat", 64'(last_wr_cyc), 64'(acc_cyc + 1));

        // timeout flush
        sb.push_back({1'b0, 2'd0, 32'h0000005A});
        beat(8'h5A, 1'b0);
        a1 = acc_cyc;
        wait_wr(4);
        chk("tmo_lat", 64'(last_wr_cyc), 64'(a1 + 17));

        // beat on the expiry cycle wins over the flush
        sb.push_back({1'b1, 2'd1, 32'h00002211});
        beat(8'h11, 1'b0);
        a1 = acc_cyc;
        cycles(15);
        beat(8'h22, 1'b1);
        chk("expiry_cycle", 64'(acc_cyc), 64'(a1 + 16));
        wait_wr(5);
        chk("expiry_lat", 64'(last_wr_cyc), 64'(acc_cyc + 1));
        cycles(3);
        chk("expiry_nwr", 64'(n_wr), 64'd5);

        // backpressure
        fifo_full_i = 1'b1;
        sb.push_back({1'b0, 2'd3, 32'h34333231});
        for (int i = 1; i <= 4; i++) beat(8'(8'h30 + i), 1'b0);
        for (int i = 0; i < 3; i++) begin
            @(negedge clk_wr);
            chk("bp_ready", 64'(in_ready_o), 64'd0);
            chk("bp_wr_en", 64'(fifo_wr_en_o), 64'd0);
            chk("bp_data", 64'(fifo_wr_data_o),
                64'({1'b0, 2'd3, 32'h34333231}));
        end
        @(posedge clk_wr);
        #1;
        fifo_full_i = 1'b0;
        #1;
        chk("rel_wr_en", 64'(fifo_wr_en_o), 64'd1);
        chk("rel_ready", 64'(in_ready_o), 64'd1);
        wait_wr(6);
        cycles(1);
        chk("words_6", 64'(words_o), 64'd6);

        // almost full
        fifo_ocup_i = 3'd2;
        cycles(1);
        chk("af_at_2", 64'(almost_full_o), 64'd0);
        fifo_ocup_i = 3'd3;
        @(negedge clk_wr);
        chk("af_lag", 64'(almost_full_o), 64'd0);
        cycles(1);
        chk("af_at_3", 64'(almost_full_o), 64'd1);
        fifo_ocup_i = 3'd0;
        cycles(1);
        chk("af_clear", 64'(almost_full_o), 64'd0);

        // reset with a blocked word pending
        fifo_full_i = 1'b1;
        for (int i = 1; i <= 4; i++) beat(8'(8'h50 + i), 1'b0);
        #2;
        arst_wr = 1'b1;
        #1;
        chk("mid_rst_ready", 64'(in_ready_o), 64'd0);
        chk("mid_rst_wr_en", 64'(fifo_wr_en_o), 64'd0);
        chk("mid_rst_words", 64'(words_o), 64'd0);
        @(posedge clk_wr);
        #1;
        arst_wr = 1'b0;
        fifo_full_i = 1'b0;
        @(negedge clk_wr);
        chk("drop_wr_en", 64'(fifo_wr_en_o), 64'd0);
        chk("drop_ready", 64'(in_ready_o), 64'd1);
        cycles(1);

        // reset mid-word, next word starts in lane 0
        beat(8'h61, 1'b0);
        beat(8'h62, 1'b0);
        #2;
        arst_wr = 1'b1;
        @(posedge clk_wr);
        #1;
        arst_wr = 1'b0;
        base = n_wr;
        chk("drop_nwr", 64'(n_wr), 64'd6);
        sb.push_back({1'b0, 2'd3, 32'h74737271});
        for (int i = 1; i <= 4; i++) beat(8'(8'h70 + i), 1'b0);
        wait_wr(base + 1);
        chk("words_after_rst", 64'(words_o), 64'd1);

        cycles(20);
        chk("sb_empty", 64'(sb.size()), 64'd0);
        chk("final_nwr", 64'(n_wr), 64'd7);
        $display("End of test - %0d assertions evaluated, %0d failures",
                 n_assert, n_fail);
        $finish;
    end

endmodule
